instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream of the single-cycle datapath.
- Replaces the bare PC register, PC+4 adder and combinational instruction-memory read with a fetch stage.
- Issues word requests to a variable-latency instruction memory and buffers returned instructions with their PCs in a small FIFO.
- Presents them to decode over a valid/ready handshake, and accepts a redirect (branch/jump target) that flushes everything fetched down the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  fetch enable; new requests are issued only while high
imem_req_o  output  1  request valid to instruction memory
imem_addr_o  output  32  word-aligned fetch address
imem_ack_i  input  1  memory response valid; meaningful only while imem_req_o=1
imem_rdata_i  input  32  instruction word, valid with imem_ack_i
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored, treated as 0
instr_valid_o  output  1  FIFO head valid
instr_o  output  32  FIFO head instruction
instr_pc_o  output  32  PC of FIFO head
instr_ready_i  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst_i=0, asynchronous):
  - imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - FIFO count=0, fetch_pc=RESET_PC, state=IDLE.
  - A response arriving after reset is ignored; memory must tolerate an abandoned request.
- All outputs are driven from registers; there is no combinational input-to-output path.
- State machine:
  - IDLE: imem_req_o=0. Moves to FETCH on the next edge when start_i=1 and count<DEPTH.
  - FETCH: imem_req_o=1, imem_addr_o=fetch_pc. Request and address are held stable until imem_ack_i=1; a request is never withdrawn.
  - On an ack (no redirect): push {imem_rdata_i, fetch_pc} into the FIFO and set fetch_pc+=4 (wraps mod 2^32).
    - Stay in FETCH if start_i=1 and post-update count<DEPTH; else go to IDLE.
    - An ack in the same cycle the request is first raised is legal, giving a sustained 1 instr/cycle.
  - DROP: imem_req_o stays 1 with the stale address. The ack is discarded with no push. Then go to FETCH at the redirected fetch_pc (or IDLE if start_i=0).
- Redirect (redirect_i=1), highest priority:
  - Next edge: count=0, fetch_pc={redirect_pc_i[31:2],2'b00}.
  - If a request is outstanding without an ack this cycle, go to DROP. Otherwise go to FETCH (start_i=1) or IDLE.
  - A request acked in the redirect cycle is discarded.
  - A pop in the redirect cycle is flushed; the consumer treats that transfer as void.
  - instr_valid_o=0 on the cycle after a redirect.
- FIFO:
  - Storage is DEPTH x 64b with a wrapping read/write pointer, plus a count in 0..DEPTH.
  - instr_valid_o = (count!=0). instr_o/instr_pc_o show the head entry and are held stable while valid and not popped.
  - Pop when instr_valid_o & instr_ready_i. Push on a non-discarded ack.
  - Push and pop in the same cycle leaves count unchanged, including at count=DEPTH-1 and count=1.
  - Push when full cannot occur, because no request is issued at count=DEPTH.
  - Pop when empty is ignored.
  - When count=DEPTH and a pop occurs with start_i=1, the request reissues on the following cycle.
- start_i falling mid-request: the outstanding request completes and its data is pushed; no new request follows.
- Ordering: instructions leave strictly in fetch order, and instr_pc_o increments by 4 between consecutive entries unless a redirect intervenes.

Test Plan:
- Zero-wait memory (ack same cycle), instr_ready_i=1, RESET_PC=0 → after the ramp, one instruction per cycle with instr_pc_o=0,4,8,12…, and instr_o matches imem[pc>>2].
- instr_ready_i=0 with zero-wait memory → exactly 4 pushes (PCs 0..12), then imem_req_o=0. Raising ready drains in order, and imem_req_o reasserts one cycle after the first pop.
- Memory with 3-cycle ack latency → imem_addr_o stays at 0x8 for all cycles until ack, and instr_valid_o rises the cycle after the ack.
- redirect_i=1, redirect_pc_i=0x103 while a request for 0x10 is unacked → DROP: the ack for 0x10 is discarded, the next request is to 0x100, the first delivered instr_pc_o is 0x100, and the FIFO is empty the cycle after the redirect.
- RESET_PC=32'hFFFF_FFF8, zero-wait → delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_i=0 mid-fetch with 2 entries buffered → imem_req_o and instr_valid_o drop immediately without a clock edge. After release, fetch restarts at RESET_PC and a late ack is not pushed.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage for the single-cycle datapath. It issues word requests to a
//   variable-latency instruction memory and buffers the returned words, tagged
//   with their PCs, in a DEPTH-entry FIFO. Decode drains the FIFO over a
//   valid/ready handshake. A redirect flushes the FIFO and restarts fetch at a
//   new PC. If a request is in flight and unacked when the redirect arrives,
//   its eventual ack is swallowed in DROP.
//
// Ports
//   clk_i, rst_i        clock / async active-low reset
//   start_i             fetch enable (gates new requests only)
//   imem_req_o/addr_o   request to instruction memory, held until imem_ack_i
//   imem_ack_i/rdata_i  memory response
//   redirect_i/pc_i     flush + restart at {redirect_pc_i[31:2],2'b00}
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i  FIFO head to decode
//
// Every output comes straight from a flop or from a register-array read, so
// no input reaches an output combinationally.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, count_post;
  logic          push, pop, can_fetch;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // Ack is acted on only in FETCH; acks seen in DROP or IDLE are never pushed.
  assign push = (state_q == FETCH) && imem_ack_i && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  // Occupancy after this cycle's push/pop. Using it in place of the current
  // count lets a pop at full reissue the request on the very next cycle.
  assign count_post = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign can_fetch  = start_i && (count_post < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_post;
    if (redirect_i) begin
      count_d    = '0;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      // An unacked request cannot be withdrawn, so its ack has to be absorbed.
      if (state_q != IDLE && !imem_ack_i) state_d = DROP;
      else                                state_d = start_i ? FETCH : IDLE;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
      case (state_q)
        IDLE:        if (can_fetch)  state_d = FETCH;
        FETCH, DROP: if (imem_ack_i) state_d = can_fetch ? FETCH : IDLE;
        default:                     state_d = IDLE;
      endcase
    end
    req_d  = (state_d != IDLE);
    // DROP keeps presenting the stale address until that request is acked.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      count_q    <= count_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{instr: imem_rdata_i, pc: fetch_pc_q};
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = mem_q[rd_ptr_q].instr;
  assign instr_pc_o    = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Random and directed stimulus drives a fetch unit connected to a
//   behavioural memory with programmable latency. The memory holds imem(a)
//   at each address a. Each time the fetch PC is (re)established, the
//   reference model queues the instruction stream that must follow: a, a+4,
//   a+8, ... A negedge monitor pops that queue on every accepted transfer.
//   A second instance, reset to 32'hFFFF_FFF8 and fed by a zero-wait memory,
//   covers PC wrap-around.
module tb_instr_fetch_unit;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, ack, redirect, ready, req, valid;
  logic [31:0] rdata, redirect_pc, addr, instr, ipc;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(ready)
  );

  logic        w_rst_n, w_start, w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_rdata;
  assign w_rdata = imem(w_addr);

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk_i(clk), .rst_i(w_rst_n), .start_i(w_start),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_req), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_pc), .instr_ready_i(1'b1)
  );

  int n_chk = 0, n_fail = 0, n_pops = 0, n_acks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Reference model: the PC stream that must reach decode from here on.
  logic [31:0] exp_q[$];
  task automatic exp_fill(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  // Memory: lat_mode >= 0 gives a fixed latency, -1 a random 0..3 per request.
  int lat_mode = 0, cur_lat = 0, wcnt = 0;
  logic ack_force;
  always begin
    @(posedge clk); #2;
    if (ack_force) begin
      ack = 1'b1; rdata = 32'hDEAD_BEEF;
    end else if (rst_n && req) begin
      if (wcnt == 0) cur_lat = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
      if (wcnt >= cur_lat) begin
        ack = 1'b1; rdata = imem(addr); wcnt = 0;
      end else begin
        ack = 1'b0; wcnt++;
      end
    end else begin
      ack = 1'b0; wcnt = 0;
    end
  end

  // Monitor
  logic        p_req = 1'b0, p_ack = 1'b0, p_redir = 1'b0, p_rst = 1'b0;
  logic [31:0] p_addr = 32'h0, e_pc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_rst && p_req && !p_ack) begin
        chk("req_held", {31'h0, req}, 32'h1);
        chk("addr_held", addr, p_addr);
      end
      if (p_rst && p_redir) chk("valid_after_redirect", {31'h0, valid}, 32'h0);
      if (req && ack) n_acks++;
      if (valid && ready && !redirect) begin
        n_pops++;
        if (exp_q.size() == 0) fail("exp_underflow");
        else begin
          e_pc = exp_q.pop_front();
          chk("head_pc", ipc, e_pc);
          chk("head_instr", instr, imem(e_pc));
        end
      end
    end
    p_req = req; p_ack = ack; p_addr = addr; p_redir = redirect; p_rst = rst_n;
  end

  // Wrap-around instance
  logic [31:0] wexp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  initial begin
    int k, cyc;
    k = 0; cyc = 0;
    @(posedge w_rst_n);
    while (k < 3 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (w_valid) begin
        chk("wrap_pc", w_pc, wexp[k]);
        chk("wrap_instr", w_instr, imem(wexp[k]));
        k++;
      end
    end
    if (k < 3) fail("wrap_timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, a0;
    bit got;
    rst_n = 0; w_rst_n = 0; start = 0; w_start = 0; redirect = 0; redirect_pc = 0;
    ready = 0; ack_force = 0; ack = 0; rdata = 0;
    exp_fill(32'h0);
    #12;
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    tick(); rst_n = 1; w_rst_n = 1;
    tick(); start = 1; ready = 1; w_start = 1;

    // Zero-wait streaming: one transfer per cycle once ramped
    repeat (10) tick();
    p0 = n_pops;
    repeat (20) tick();
    chk("throughput", 32'(n_pops - p0), 32'd20);

    // Stalled consumer fills exactly DEPTH entries, then fetch stops
    redirect = 1; redirect_pc = 32'h0; ready = 0; exp_fill(32'h0);
    tick(); redirect = 0;
    a0 = n_acks;
    repeat (15) tick();
    chk("acks_while_stalled", 32'(n_acks - a0), 32'd4);
    chk("req_off_when_full", {31'h0, req}, 32'h0);
    ready = 1;
    @(negedge clk); chk("req_before_pop", {31'h0, req}, 32'h0);
    @(negedge clk); chk("req_after_pop", {31'h0, req}, 32'h1);
    tick(); repeat (20) tick();

    // 3-cycle memory latency at 0x8
    start = 0; repeat (8) tick();
    lat_mode = 3; redirect = 1; redirect_pc = 32'h8; start = 1; exp_fill(32'h8);
    tick(); redirect = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1;
      else begin
        chk("lat_addr", addr, 32'h8);
        chk("lat_valid_wait", {31'h0, valid}, 32'h0);
      end
    end
    if (!got) fail("lat_ack_timeout");
    else begin
      chk("valid_at_ack", {31'h0, valid}, 32'h0);
      @(negedge clk); chk("valid_after_ack", {31'h0, valid}, 32'h1);
    end
    tick(); start = 0; lat_mode = 0;
    repeat (8) tick();

    // Redirect while 0x10 is unacked -> DROP, then restart at 0x100
    lat_mode = 5; redirect = 1; redirect_pc = 32'h10; start = 1; exp_fill(32'h10);
    tick(); redirect = 0;
    tick(); tick();
    redirect = 1; redirect_pc = 32'h103; lat_mode = 0; exp_fill(32'h100);
    tick(); redirect = 0;
    @(negedge clk);
    chk("drop_req", {31'h0, req}, 32'h1);
    chk("drop_addr", addr, 32'h10);
    chk("drop_valid", {31'h0, valid}, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req && addr != 32'h10) got = 1;
    end
    if (!got) fail("drop_timeout");
    else chk("post_drop_addr", addr, 32'h100);
    tick(); repeat (10) tick();

    // Async reset mid-fetch with two entries buffered
    ready = 0; redirect = 1; redirect_pc = 32'h40; exp_fill(32'h40);
    tick(); redirect = 0;
    tick();
    tick(); lat_mode = 8;
    tick();
    chk("pre_rst_valid", {31'h0, valid}, 32'h1);
    chk("pre_rst_req", {31'h0, req}, 32'h1);
    rst_n = 0; exp_fill(32'h0);
    #1;
    chk("rst_async_req", {31'h0, req}, 32'h0);
    chk("rst_async_valid", {31'h0, valid}, 32'h0);
    chk("rst_async_addr", addr, 32'h0);
    start = 0;
    tick(); rst_n = 1; ack_force = 1; lat_mode = 0;
    tick(); tick(); ack_force = 0;
    chk("late_ack_ignored", {31'h0, valid}, 32'h0);
    chk("late_ack_no_req", {31'h0, req}, 32'h0);
    ready = 1; start = 1;
    repeat (15) tick();

    // Randomized phase
    lat_mode = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      ready    = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 7) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      if (redirect) begin
        redirect_pc = $urandom;
        exp_fill({redirect_pc[31:2], 2'b00});
      end
    end
    tick(); redirect = 0;
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
